alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream command stage for the 4-bit ALU: queues op commands, reads a 4x4-bit register file, drives a/b/alu_sel
//  into the combinational ALU and writes back alu_out plus carry/zero flags one cycle later.
//  This turns the combinational ALU into a pipelined register-to-register datapath with a valid/ready command port.
// PARAMETERS
//  FIFO_DEPTH  4  command queue entries (power of 2, >=2)
//  NUM_REGS    4  register file entries; address width = 2
//  DATA_W      4  operand width; fixed at 4 to match the ALU
// PORTS
//  clk          in   1  clock, all state on rising edge
//  rst          in   1  synchronous, active-high reset
//  cmd_valid    in   1  command present
//  cmd_ready    out  1  queue can accept; handshake = valid & ready at the edge
//  cmd_op       in   3  000 AND,001 OR,010 XOR,011 ADD,100 SUB,111 LDI; 101/110 illegal
//  cmd_rd       in   2  destination register
//  cmd_ra       in   2  operand A register
//  cmd_rb       in   2  operand B register
//  cmd_imm      in   4  immediate, used by LDI only
//  hold         in   1  1 = do not pop the queue into EX (in-flight EX op still completes)
//  alu_a        out  4  ALU operand A (registered)
//  alu_b        out  4  ALU operand B (registered)
//  alu_sel      out  3  ALU select (registered)
//  alu_out      in   4  ALU result
//  alu_carry    in   1  ALU carry/borrow
//  alu_zero     in   1  ALU zero
//  wb_valid     out  1  1-cycle pulse: register written this cycle
//  wb_rd        out  2  register written
//  wb_data      out  4  value written
//  flag_c       out  1  sticky carry flag
//  flag_z       out  1  sticky zero flag
//  err_illegal  out  1  1-cycle pulse: an illegal op was retired
//  busy         out  1  queue non-empty or EX occupied
//  dbg_addr     in   2  debug read address
//  dbg_data     out  4  regfile[dbg_addr], combinational
// BEHAVIOUR
//  Reset: queue emptied, EX invalid, all regs = 0, alu_a/alu_b/alu_sel = 0, flags = 0, wb_valid/err_illegal = 0,
//   cmd_ready = 1 in the cycle after reset deasserts. Reset mid-stream discards every queued or in-flight command, no write.
//  Queue: cmd_ready = !full. Push and pop in one cycle are legal when the queue is non-empty. Order is strict FIFO.
//   Pointers wrap modulo FIFO_DEPTH.
//  Issue (edge T1): if queue non-empty & !hold, pop head into EX. Register alu_a = R[ra], alu_b = R[rb] and alu_sel = op
//   (LDI/illegal: alu_sel = 000). EX valid for the cycle T1..T2.
//  Forwarding: if the op leaving EX at T1 writes rd == ra/rb of the op entering, use its result (alu_out, or imm for LDI).
//   Never use the stale regfile value.
//  Writeback (edge T2): ALU op -> R[rd] = alu_out, flag_c = alu_carry, flag_z = alu_zero.
//   LDI -> R[rd] = imm, flags unchanged. Illegal -> no write, flags unchanged, err_illegal = 1.
//   wb_valid/wb_rd/wb_data are registered and valid for one cycle after T2.
//  Latency: accepted at T0 into an empty queue -> issued at T1 -> written at T2. One op retires per cycle in steady state.
//  hold=1: no pop; the EX op still retires. busy = !empty | ex_valid.
//  No dbg read bypass: dbg_data reflects the regfile after the edge.
// STRUCTURE
//  Shared package alu_pkg: OP_AND..OP_SUB, OP_LDI, opcode width, DATA_W, and the cmd struct/field order {op,rd,ra,rb,imm}.
//  The ALU opcode constants move here too.
//  Sub-module alu_cmd_fifo: parameterised sync FIFO with push/pop/full/empty. Regfile, EX register and forwarding stay top-level.
// TESTING (bench instantiates the 4-bit ALU on alu_a/alu_b/alu_sel)
//  1. LDI r0=5, LDI r1=3, ADD r2=r0+r1 back-to-back -> wb r2=8, flag_c=0, flag_z=0; checks forwarding. Latency 2 from accept.
//  2. LDI r0=9, LDI r1=9, ADD r2 -> r2=4'h2, flag_c=1, flag_z=0. Then LDI r3=0 -> flags still c=1, z=0.
//  3. SUB r3=r0-r0 (r0=9) -> r3=0, flag_z=1, flag_c = ALU borrow (0).
//  4. hold=1, push 4 cmds -> cmd_ready=0 after 4th, 5th stalls. hold=0 -> 5 writebacks in push order on consecutive cycles.
//  5. op=101, rd=r1 -> err_illegal pulse, no wb_valid, r1 and flags unchanged.
//  6. rst with 2 queued + 1 in EX -> next cycle busy=0, wb_valid=0, all dbg_data reads 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and command layout for the ALU command sequencer
// Purpose: one place for the ALU select encoding and the queued command format so the
//          sequencer, its queue and the bench all agree on field order {op,rd,ra,rb,imm}.
// Ports:   none (package)
package alu_pkg;

   localparam int DATA_W   = 4;
   localparam int OP_W     = 3;
   localparam int NUM_REGS = 4;
   localparam int REG_AW   = 2;

   // Select values double as the ALU's alu_sel encoding; 101/110 are reserved.
   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_ADD  = 3'b011,
      OP_SUB  = 3'b100,
      OP_RSV5 = 3'b101,
      OP_RSV6 = 3'b110,
      OP_LDI  = 3'b111
   } alu_op_e;

   typedef struct packed {
      alu_op_e             op;
      logic [REG_AW-1:0]   rd;
      logic [REG_AW-1:0]   ra;
      logic [REG_AW-1:0]   rb;
      logic [DATA_W-1:0]   imm;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // True for opcodes that are evaluated by the external ALU.
   function automatic logic op_is_alu(input alu_op_e op);
      logic w_res;
      w_res = 1'b0;
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: w_res = 1'b1;
         default:                               w_res = 1'b0;
      endcase
      return w_res;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous FIFO holding queued ALU commands
// Purpose: strict-order command queue; push and pop may occur in the same cycle.
// Ports:   clk/rst     clock, synchronous active-high reset (empties the queue)
//          push, din   write request and data (ignored when full)
//          pop, dout   read request (ignored when empty) and head-of-queue data
//          full, empty occupancy status
module alu_cmd_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the indices match.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_do_push;
   logic w_do_pop;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queued register-to-register front end for the 4-bit ALU
// Purpose: accepts commands on a valid/ready port, issues them from a FIFO into a single
//          EX stage that drives the combinational ALU, and writes results back one cycle later.
// Ports:   clk, rst                              clock, synchronous active-high reset
//          cmd_valid/cmd_ready, cmd_op/rd/ra/rb/imm  command port
//          hold                                  stop issuing from the queue
//          alu_a, alu_b, alu_sel                 registered ALU operands/select
//          alu_out, alu_carry, alu_zero          ALU results
//          wb_valid, wb_rd, wb_data              registered writeback report
//          flag_c, flag_z                        sticky flags from the last ALU op
//          err_illegal                           pulse when a reserved opcode retires
//          busy                                  queue non-empty or EX occupied
//          dbg_addr, dbg_data                    combinational register file read
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [REG_AW-1:0] cmd_rd,
   input  logic [REG_AW-1:0] cmd_ra,
   input  logic [REG_AW-1:0] cmd_rb,
   input  logic [DATA_W-1:0] cmd_imm,
   input  logic              hold,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   input  logic              alu_zero,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              flag_c,
   output logic              flag_z,
   output logic              err_illegal,
   output logic              busy,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   // Queue
   cmd_t w_cmd_in;
   cmd_t w_head;
   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Architectural and pipeline state
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              r_ex_valid;
   alu_op_e           r_ex_op;
   logic [REG_AW-1:0] r_ex_rd;
   logic [DATA_W-1:0] r_ex_imm;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [OP_W-1:0]   r_alu_sel;
   logic              r_wb_valid;
   logic [REG_AW-1:0] r_wb_rd;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_flag_c;
   logic              r_flag_z;
   logic              r_err;

   // EX retirement
   logic              w_ex_is_alu;
   logic              w_ex_is_ldi;
   logic              w_ex_we;
   logic              w_ex_ill;
   logic [DATA_W-1:0] w_ex_result;
   logic [DATA_W-1:0] w_opa;
   logic [DATA_W-1:0] w_opb;

   assign w_cmd_in  = {cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm};
   assign cmd_ready = !w_full;
   assign w_push    = cmd_valid && cmd_ready;
   assign w_pop     = !w_empty && !hold;

   alu_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .din   (w_cmd_in),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   assign w_ex_is_alu = op_is_alu(r_ex_op);
   assign w_ex_is_ldi = (r_ex_op == OP_LDI);
   assign w_ex_we     = r_ex_valid && (w_ex_is_alu || w_ex_is_ldi);
   assign w_ex_ill    = r_ex_valid && !(w_ex_is_alu || w_ex_is_ldi);
   assign w_ex_result = w_ex_is_ldi ? r_ex_imm : alu_out;

   // The op retiring at this edge has not reached the register file yet, so an
   // issuing op that reads its destination must take the result directly.
   assign w_opa = (w_ex_we && (r_ex_rd == w_head.ra)) ? w_ex_result : r_regs[w_head.ra];
   assign w_opb = (w_ex_we && (r_ex_rd == w_head.rb)) ? w_ex_result : r_regs[w_head.rb];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_ex_valid <= 1'b0;
         r_ex_op    <= OP_AND;
         r_ex_rd    <= '0;
         r_ex_imm   <= '0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_sel  <= '0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_flag_c   <= 1'b0;
         r_flag_z   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_wb_valid <= w_ex_we;
         r_err      <= w_ex_ill;

         if (w_ex_we) begin
            r_regs[r_ex_rd] <= w_ex_result;
            r_wb_rd         <= r_ex_rd;
            r_wb_data       <= w_ex_result;
         end
         // LDI and reserved ops leave the flags untouched.
         if (r_ex_valid && w_ex_is_alu) begin
            r_flag_c <= alu_carry;
            r_flag_z <= alu_zero;
         end

         if (w_pop) begin
            r_ex_valid <= 1'b1;
            r_ex_op    <= w_head.op;
            r_ex_rd    <= w_head.rd;
            r_ex_imm   <= w_head.imm;
            r_alu_a    <= w_opa;
            r_alu_b    <= w_opb;
            // Non-ALU ops park the select at AND; the ALU result is ignored for them.
            r_alu_sel  <= op_is_alu(w_head.op) ? w_head.op : OP_AND;
         end else begin
            r_ex_valid <= 1'b0;
         end
      end
   end

   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_sel     = r_alu_sel;
   assign wb_valid    = r_wb_valid;
   assign wb_rd       = r_wb_rd;
   assign wb_data     = r_wb_data;
   assign flag_c      = r_flag_c;
   assign flag_z      = r_flag_z;
   assign err_illegal = r_err;
   assign busy        = !w_empty || r_ex_valid;
   assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed scoreboard bench for alu_cmd_sequencer with a 4-bit ALU model
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_rd, cmd_ra, cmd_rb;
   logic [3:0] cmd_imm;
   logic       hold;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_out;
   logic       alu_carry, alu_zero;
   logic       wb_valid;
   logic [1:0] wb_rd;
   logic [3:0] wb_data;
   logic       flag_c, flag_z, err_illegal, busy;
   logic [1:0] dbg_addr;
   logic [3:0] dbg_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [1:0] rd;
      logic [3:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [3:0] m_regs [4];
   logic       m_fc, m_fz;

   alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
      .hold(hold),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flag_c(flag_c), .flag_z(flag_z), .err_illegal(err_illegal), .busy(busy),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // {carry, result}; SUB carry is the borrow (a < b).
   function automatic logic [4:0] alu_model(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
      case (sel)
         3'b000:  return {1'b0, a & b};
         3'b001:  return {1'b0, a | b};
         3'b010:  return {1'b0, a ^ b};
         3'b011:  return {1'b0, a} + {1'b0, b};
         3'b100:  return {(a < b), 4'(a - b)};
         default: return 5'd0;
      endcase
   endfunction

   always_comb begin
      {alu_carry, alu_out} = alu_model(alu_sel, alu_a, alu_b);
      alu_zero = (alu_out == 4'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void sb_push(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                                   input logic [1:0] rb, input logic [3:0] imm, input int ec);
      logic [4:0] r;
      if (op <= 3'b100) begin
         r = alu_model(op, m_regs[ra], m_regs[rb]);
         m_regs[rd] = r[3:0];
         m_fc = r[4];
         m_fz = (r[3:0] == 4'd0);
         sb.push_back('{rd, r[3:0], ec});
      end else if (op == 3'b111) begin
         m_regs[rd] = imm;
         sb.push_back('{rd, imm, ec});
      end
   endfunction

   // Scoreboard consumer: every writeback must match the next expected one in order.
   always @(negedge clk) begin
      if (!rst && wb_valid) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", 32'(wb_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_data", 32'(wb_data), 32'(e.data));
            if (e.cyc >= 0) chk("wb_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [3:0] imm, input bit track, input int lat);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         chk("send_timeout", 32'(cmd_ready), 32'd1);
      end else begin
         @(posedge clk); #1;
         if (track) sb_push(op, rd, ra, rb, imm, (lat < 0) ? -1 : cyc + lat);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_flag_c"}, 32'(flag_c), 32'(m_fc));
      chk({tag, "_flag_z"}, 32'(flag_z), 32'(m_fz));
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; hold = 1'b0; cmd_valid = 1'b0;
      cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0; dbg_addr = '0;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_fc = 1'b0; m_fz = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_sel", 32'(alu_sel), 32'd0);
      check_state("rst");

      // 1: LDI/LDI/ADD back-to-back, forwarding, latency 2
      send(3'b111, 2'd0, 2'd0, 2'd0, 4'd5, 1, 2);
      send(3'b111, 2'd1, 2'd0, 2'd0, 4'd3, 1, 2);
      send(3'b011, 2'd2, 2'd0, 2'd1, 4'd0, 1, 2);
      drain();
      check_state("t1");

      // 2: carry out, then LDI leaves flags alone
      send(3'b111, 2'd0, 2'd0, 2'd0, 4'd9, 1, 2);
      send(3'b111, 2'd1, 2'd0, 2'd0, 4'd9, 1, 2);
      send(3'b011, 2'd2, 2'd0, 2'd1, 4'd0, 1, 2);
      send(3'b111, 2'd3, 2'd0, 2'd0, 4'd0, 1, 2);
      drain();
      check_state("t2");

      // 3: SUB to zero, then ALU-result forwarding chain
      send(3'b100, 2'd3, 2'd0, 2'd0, 4'd0, 1, 2);
      drain();
      check_state("t3");
      send(3'b011, 2'd1, 2'd0, 2'd0, 4'd0, 1, 2);
      send(3'b001, 2'd2, 2'd1, 2'd3, 4'd0, 1, 2);
      drain();
      check_state("t3b");

      // 4: hold fills the queue, fifth stalls, release drains in order on consecutive cycles
      hold = 1'b1;
      send(3'b111, 2'd0, 2'd0, 2'd0, 4'd1, 1, -1);
      send(3'b111, 2'd1, 2'd0, 2'd0, 4'd2, 1, -1);
      send(3'b011, 2'd2, 2'd0, 2'd1, 4'd0, 1, -1);
      send(3'b100, 2'd3, 2'd2, 2'd0, 4'd0, 1, -1);
      chk("full_ready", 32'(cmd_ready), 32'd0);
      chk("held_busy", 32'(busy), 32'd1);
      cmd_valid = 1'b1;
      cmd_op = 3'b000; cmd_rd = 2'd0; cmd_ra = 2'd3; cmd_rb = 2'd2; cmd_imm = 4'd0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("stall_ready", 32'(cmd_ready), 32'd0);
         chk("stall_wb", 32'(wb_valid), 32'd0);
      end
      hold = 1'b0;
      @(posedge clk); #1;
      chk("release_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      sb_push(3'b000, 2'd0, 2'd3, 2'd2, 4'd0, -1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("burst_wb%0d", i), 32'(wb_valid), 32'd1);
      end
      drain();
      check_state("t4");

      // 5: illegal opcode retires with an error pulse and no write
      send(3'b101, 2'd1, 2'd0, 2'd0, 4'd0, 0, -1);
      @(negedge clk);
      @(negedge clk);
      chk("ill_err_early", 32'(err_illegal), 32'd0);
      @(negedge clk);
      chk("ill_err", 32'(err_illegal), 32'd1);
      chk("ill_wb", 32'(wb_valid), 32'd0);
      @(negedge clk);
      chk("ill_err_pulse", 32'(err_illegal), 32'd0);
      drain();
      check_state("t5");

      // 6: reset with two queued and one in EX
      hold = 1'b1;
      send(3'b111, 2'd0, 2'd0, 2'd0, 4'd7, 0, -1);
      send(3'b111, 2'd1, 2'd0, 2'd0, 4'd8, 0, -1);
      send(3'b111, 2'd2, 2'd0, 2'd0, 4'd9, 0, -1);
      hold = 1'b0;
      @(posedge clk); #1;
      hold = 1'b1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      hold = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_fc = 1'b0; m_fz = 1'b0;
      @(negedge clk);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_wb_valid", 32'(wb_valid), 32'd0);
      chk("t6_ready", 32'(cmd_ready), 32'd1);
      check_state("t6");
      @(negedge clk);
      chk("t6_wb_after", 32'(wb_valid), 32'd0);
      chk("t6_busy_after", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
